// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : RV32I decode stage. Decodes fields, immediate, format and
//               legality from the fetched word into a one-entry pipeline
//               register with stall/done handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
    localparam int ADDR_WIDTH        = 32,
    localparam int INSTRUCTION_WIDTH = 32,
    localparam int DATA_WIDTH        = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         stall_prev,
    input  logic                         prev_done,
    input  logic                         next_stall,
    output logic                         done_next,
    input  logic [ADDR_WIDTH-1:0]        program_count_in,
    input  logic                         program_count_valid_in,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction_data_in,
    input  logic                         instruction_data_valid_in,
    output logic [ADDR_WIDTH-1:0]        program_count_out,
    output logic                         program_count_valid_out,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
    output logic [6:0]                   opcode_out,
    output logic [4:0]                   rd_out,
    output logic [4:0]                   rs1_out,
    output logic [4:0]                   rs2_out,
    output logic [2:0]                   funct3_out,
    output logic [6:0]                   funct7_out,
    output logic [DATA_WIDTH-1:0]        imm_out,
    output logic [2:0]                   format_out,
    output logic                         rd_write_out,
    output logic                         rs1_used_out,
    output logic                         rs2_used_out,
    output logic                         illegal_out,
    output logic                         fetch_fault_out
);

    localparam logic [2:0] c_FMT_R    = 3'd0;
    localparam logic [2:0] c_FMT_I    = 3'd1;
    localparam logic [2:0] c_FMT_S    = 3'd2;
    localparam logic [2:0] c_FMT_B    = 3'd3;
    localparam logic [2:0] c_FMT_U    = 3'd4;
    localparam logic [2:0] c_FMT_J    = 3'd5;
    localparam logic [2:0] c_FMT_NONE = 3'd7;

    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] c_OP_FENCE  = 7'b0001111;

    logic                  r_has_input;
    logic                  w_transfer_next;
    logic                  w_transfer_prev;
    logic [6:0]            w_opcode;
    logic [4:0]            w_rd;
    logic [2:0]            w_format;
    logic [DATA_WIDTH-1:0] w_imm;
    logic                  w_illegal;
    logic                  w_rd_write;
    logic                  w_rs1_used;
    logic                  w_rs2_used;
    logic                  w_sign;

    assign done_next       = rst && r_has_input;
    assign w_transfer_next = done_next && !next_stall;
    assign stall_prev      = !rst || (r_has_input && !w_transfer_next);
    assign w_transfer_prev = prev_done && !stall_prev;

    assign w_opcode = instruction_data_in[6:0];
    assign w_rd     = instruction_data_in[11:7];
    assign w_sign   = instruction_data_in[31];

    always_comb begin
        w_format = c_FMT_NONE;
        case (w_opcode)
            7'b0110011:                                         w_format = c_FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111, c_OP_SYSTEM, c_OP_FENCE: w_format = c_FMT_I;
            7'b0100011:                                         w_format = c_FMT_S;
            7'b1100011:                                         w_format = c_FMT_B;
            7'b0110111, 7'b0010111:                             w_format = c_FMT_U;
            7'b1101111:                                         w_format = c_FMT_J;
            default:                                            w_format = c_FMT_NONE;
        endcase
        // A faulted word carries no meaning, so it decodes as "no format",
        // which also zeroes the immediate and every usage flag below.
        if (!instruction_data_valid_in) begin
            w_format = c_FMT_NONE;
        end

        w_illegal = !instruction_data_valid_in || (w_format == c_FMT_NONE) ||
                    (instruction_data_in[1:0] != 2'b11);

        w_imm = '0;
        case (w_format)
            c_FMT_I: w_imm = {{20{w_sign}}, instruction_data_in[31:20]};
            c_FMT_S: w_imm = {{20{w_sign}}, instruction_data_in[31:25], instruction_data_in[11:7]};
            c_FMT_B: w_imm = {{19{w_sign}}, w_sign, instruction_data_in[7],
                              instruction_data_in[30:25], instruction_data_in[11:8], 1'b0};
            c_FMT_U: w_imm = {instruction_data_in[31:12], 12'b0};
            c_FMT_J: w_imm = {{11{w_sign}}, w_sign, instruction_data_in[19:12],
                              instruction_data_in[20], instruction_data_in[30:21], 1'b0};
            default: w_imm = '0;
        endcase

        w_rd_write = ((w_format == c_FMT_R) || (w_format == c_FMT_I) ||
                      (w_format == c_FMT_U) || (w_format == c_FMT_J)) && (w_rd != 5'd0);
        w_rs1_used = ((w_format == c_FMT_R) || (w_format == c_FMT_I) ||
                      (w_format == c_FMT_S) || (w_format == c_FMT_B)) &&
                     (w_opcode != c_OP_SYSTEM) && (w_opcode != c_OP_FENCE);
        w_rs2_used = (w_format == c_FMT_R) || (w_format == c_FMT_S) || (w_format == c_FMT_B);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_has_input             <= 1'b0;
            program_count_out       <= '0;
            program_count_valid_out <= 1'b0;
            instruction_out         <= '0;
            opcode_out              <= '0;
            rd_out                  <= '0;
            rs1_out                 <= '0;
            rs2_out                 <= '0;
            funct3_out              <= '0;
            funct7_out              <= '0;
            imm_out                 <= '0;
            format_out              <= c_FMT_NONE;
            rd_write_out            <= 1'b0;
            rs1_used_out            <= 1'b0;
            rs2_used_out            <= 1'b0;
            illegal_out             <= 1'b0;
            fetch_fault_out         <= 1'b0;
        end else if (!r_has_input || w_transfer_next) begin
            // Draining and refilling in the same cycle keeps full throughput.
            r_has_input <= w_transfer_prev;
            if (w_transfer_prev) begin
                program_count_out       <= program_count_in;
                program_count_valid_out <= program_count_valid_in;
                instruction_out         <= instruction_data_in;
                opcode_out              <= w_opcode;
                rd_out                  <= w_rd;
                rs1_out                 <= instruction_data_in[19:15];
                rs2_out                 <= instruction_data_in[24:20];
                funct3_out              <= instruction_data_in[14:12];
                funct7_out              <= instruction_data_in[31:25];
                imm_out                 <= w_imm;
                format_out              <= w_format;
                rd_write_out            <= w_rd_write;
                rs1_used_out            <= w_rs1_used;
                rs2_used_out            <= w_rs2_used;
                illegal_out             <= w_illegal;
                fetch_fault_out         <= !instruction_data_valid_in;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Directed and random stimulus for decode_stage, checked
//               against a behavioural decode/handshake reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    typedef struct {
        logic [31:0] pc;
        logic        pcv;
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic        rdw;
        logic        r1u;
        logic        r2u;
        logic        ill;
        logic        ff;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_prev;
    logic        prev_done;
    logic        next_stall;
    logic        done_next;
    logic [31:0] program_count_in;
    logic        program_count_valid_in;
    logic [31:0] instruction_data_in;
    logic        instruction_data_valid_in;
    logic [31:0] program_count_out;
    logic        program_count_valid_out;
    logic [31:0] instruction_out;
    logic [6:0]  opcode_out;
    logic [4:0]  rd_out;
    logic [4:0]  rs1_out;
    logic [4:0]  rs2_out;
    logic [2:0]  funct3_out;
    logic [6:0]  funct7_out;
    logic [31:0] imm_out;
    logic [2:0]  format_out;
    logic        rd_write_out;
    logic        rs1_used_out;
    logic        rs2_used_out;
    logic        illegal_out;
    logic        fetch_fault_out;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_en = 1'b0;
    bit   m_has = 1'b0;
    exp_t m_e;

    always #5 clk = ~clk;

    decode_stage u_dut (
        .clk                       (clk),
        .rst                       (rst),
        .stall_prev                (stall_prev),
        .prev_done                 (prev_done),
        .next_stall                (next_stall),
        .done_next                 (done_next),
        .program_count_in          (program_count_in),
        .program_count_valid_in    (program_count_valid_in),
        .instruction_data_in       (instruction_data_in),
        .instruction_data_valid_in (instruction_data_valid_in),
        .program_count_out         (program_count_out),
        .program_count_valid_out   (program_count_valid_out),
        .instruction_out           (instruction_out),
        .opcode_out                (opcode_out),
        .rd_out                    (rd_out),
        .rs1_out                   (rs1_out),
        .rs2_out                   (rs2_out),
        .funct3_out                (funct3_out),
        .funct7_out                (funct7_out),
        .imm_out                   (imm_out),
        .format_out                (format_out),
        .rd_write_out              (rd_write_out),
        .rs1_used_out              (rs1_used_out),
        .rs2_used_out              (rs2_used_out),
        .illegal_out               (illegal_out),
        .fetch_fault_out           (fetch_fault_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode: format from the opcode table, immediates built by
    // masking/shifting the word rather than by bit concatenation.
    function automatic exp_t ref_decode(input logic [31:0] pc, input logic pcv,
                                        input logic [31:0] x, input logic valid);
        exp_t        e;
        logic [31:0] sgn;
        sgn     = x[31] ? 32'hFFFF_FFFF : 32'h0;
        e.pc    = pc;
        e.pcv   = pcv;
        e.instr = x;
        e.ff    = !valid;
        case (x[6:0])
            7'h33:                             e.fmt = 3'd0;
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: e.fmt = 3'd1;
            7'h23:                             e.fmt = 3'd2;
            7'h63:                             e.fmt = 3'd3;
            7'h37, 7'h17:                      e.fmt = 3'd4;
            7'h6F:                             e.fmt = 3'd5;
            default:                           e.fmt = 3'd7;
        endcase
        if (!valid) e.fmt = 3'd7;
        case (e.fmt)
            3'd1:    e.imm = (sgn << 12) | (x >> 20);
            3'd2:    e.imm = (sgn << 12) | ((x >> 25) << 5) | ((x >> 7) & 32'd31);
            3'd3:    e.imm = (sgn << 12) | (((x >> 7) & 32'd1) << 11) |
                             (((x >> 25) & 32'd63) << 5) | (((x >> 8) & 32'd15) << 1);
            3'd4:    e.imm = x & 32'hFFFF_F000;
            3'd5:    e.imm = (sgn << 20) | (x & 32'h000F_F000) |
                             (((x >> 20) & 32'd1) << 11) | (((x >> 21) & 32'd1023) << 1);
            default: e.imm = 32'h0;
        endcase
        e.ill = (e.fmt == 3'd7) || (x[1:0] != 2'b11);
        e.rdw = (e.fmt inside {3'd0, 3'd1, 3'd4, 3'd5}) && (((x >> 7) & 32'd31) != 0);
        e.r1u = (e.fmt inside {3'd0, 3'd1, 3'd2, 3'd3}) && !(x[6:0] inside {7'h73, 7'h0F});
        e.r2u = e.fmt inside {3'd0, 3'd2, 3'd3};
        return e;
    endfunction

    function automatic exp_t reset_entry();
        exp_t e;
        e = '{pc: 32'h0, pcv: 1'b0, instr: 32'h0, fmt: 3'd7, imm: 32'h0,
              rdw: 1'b0, r1u: 1'b0, r2u: 1'b0, ill: 1'b0, ff: 1'b0};
        return e;
    endfunction

    // One clock: check everything against the model, clock, advance the model.
    task automatic cyc();
        bit tn;
        bit tp;
        bit st;
        #1;
        tn = rst && m_has && !next_stall;
        st = !rst || (m_has && !tn);
        tp = prev_done && !st;
        if (chk_en) begin
            chk("done_next", 32'(done_next), 32'(rst && m_has));
            chk("stall_prev", 32'(stall_prev), 32'(st));
            chk("pc", program_count_out, m_e.pc);
            chk("pc_valid", 32'(program_count_valid_out), 32'(m_e.pcv));
            chk("instr", instruction_out, m_e.instr);
            chk("opcode", 32'(opcode_out), m_e.instr & 32'h7F);
            chk("rd", 32'(rd_out), (m_e.instr >> 7) & 32'd31);
            chk("rs1", 32'(rs1_out), (m_e.instr >> 15) & 32'd31);
            chk("rs2", 32'(rs2_out), (m_e.instr >> 20) & 32'd31);
            chk("funct3", 32'(funct3_out), (m_e.instr >> 12) & 32'd7);
            chk("funct7", 32'(funct7_out), m_e.instr >> 25);
            chk("imm", imm_out, m_e.imm);
            chk("format", 32'(format_out), 32'(m_e.fmt));
            chk("rd_write", 32'(rd_write_out), 32'(m_e.rdw));
            chk("rs1_used", 32'(rs1_used_out), 32'(m_e.r1u));
            chk("rs2_used", 32'(rs2_used_out), 32'(m_e.r2u));
            chk("illegal", 32'(illegal_out), 32'(m_e.ill));
            chk("fetch_fault", 32'(fetch_fault_out), 32'(m_e.ff));
        end
        @(posedge clk);
        if (!rst) begin
            m_has = 1'b0;
            m_e   = reset_entry();
        end else if (!m_has || tn) begin
            m_has = tp;
            if (tp) m_e = ref_decode(program_count_in, program_count_valid_in,
                                     instruction_data_in, instruction_data_valid_in);
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit pd, input logic [31:0] pc, input logic [31:0] w, input bit v);
        prev_done                 = pd;
        program_count_in          = pc;
        program_count_valid_in    = 1'b1;
        instruction_data_in       = w;
        instruction_data_valid_in = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] ops [12] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F,
                                 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
        logic [31:0] w;

        rst = 1'b0;
        next_stall = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        cyc();
        chk_en = 1'b1;
        cyc();
        chk("reset_format", 32'(format_out), 32'd7);
        rst = 1'b1;

        // ADDI x1,x2,-1
        drive(1'b1, 32'h100, 32'hFFF1_0093, 1'b1);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        chk("addi_imm", imm_out, 32'hFFFF_FFFF);
        chk("addi_fmt", 32'(format_out), 32'd1);
        chk("addi_pc", program_count_out, 32'h100);
        cyc();

        // SW x5,8(x6)
        drive(1'b1, 32'h104, 32'h0053_2423, 1'b1);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        chk("sw_imm", imm_out, 32'h8);
        chk("sw_rs2_used", 32'(rs2_used_out), 32'd1);
        cyc();

        // LUI then JAL back to back: no bubble
        drive(1'b1, 32'h108, 32'h1234_51B7, 1'b1);
        cyc();
        drive(1'b1, 32'h10C, 32'hFFDF_F06F, 1'b1);
        chk("lui_done", 32'(done_next), 32'd1);
        chk("lui_imm", imm_out, 32'h1234_5000);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        chk("jal_done", 32'(done_next), 32'd1);
        chk("jal_imm", imm_out, 32'hFFFF_FFFC);
        chk("jal_rd_write", 32'(rd_write_out), 32'd0);
        cyc();

        // Downstream stall for 3 cycles with a second word pending
        drive(1'b1, 32'h200, 32'h0020_8133, 1'b1);
        cyc();
        next_stall = 1'b1;
        drive(1'b1, 32'h204, 32'h0041_0193, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_hold", 32'(stall_prev), 32'd1);
            cyc();
            chk("stall_stable", instruction_out, 32'h0020_8133);
        end
        next_stall = 1'b0;
        cyc();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        chk("refill_instr", instruction_out, 32'h0041_0193);
        chk("refill_done", 32'(done_next), 32'd1);
        cyc();

        // Illegal opcode, then fetch fault
        drive(1'b1, 32'h300, 32'h0000_007F, 1'b1);
        cyc();
        drive(1'b1, 32'h304, 32'h0053_2423, 1'b0);
        chk("ill_fmt", 32'(format_out), 32'd7);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        chk("ff_flag", 32'(fetch_fault_out), 32'd1);
        chk("ff_imm", imm_out, 32'h0);
        chk("ff_pc", program_count_out, 32'h304);
        cyc();

        // Reset while occupied and stalled
        drive(1'b1, 32'h400, 32'h0010_0093, 1'b1);
        next_stall = 1'b1;
        cyc();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        cyc();
        chk("rst_done", 32'(done_next), 32'd0);
        chk("rst_stall", 32'(stall_prev), 32'd1);
        chk("rst_fmt", 32'(format_out), 32'd7);
        rst = 1'b1;
        next_stall = 1'b0;
        drive(1'b1, 32'h408, 32'h0000_0013, 1'b1);
        cyc();
        chk("post_rst_accept", 32'(done_next), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            w = $urandom;
            if ($urandom_range(0, 9) < 8) w[6:0] = ops[$urandom_range(0, 11)];
            rst        = ($urandom_range(0, 39) != 0);
            next_stall = ($urandom_range(0, 9) < 3);
            drive($urandom_range(0, 9) < 7, $urandom, w, $urandom_range(0, 9) != 0);
            program_count_valid_in = 1'($urandom);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
